// File: rtl/taxi_axis_cobs_decode_if.sv
// taxi_axis_cobs_decode_if: AXI4-Stream bundle used on both sides
// of the COBS decoder.
interface taxi_axis_cobs_decode_if #(
  parameter int DATA_W = 8,
  parameter int USER_W = 1
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [DATA_W/8-1:0] tstrb;
  logic                tvalid;
  logic                tready;
  logic                tlast;
  logic [USER_W-1:0]   tuser;

  modport src (
    output tdata, tkeep, tstrb, tvalid, tlast, tuser,
    input  tready
  );

  modport snk (
    input  tdata, tkeep, tstrb, tvalid, tlast, tuser,
    output tready
  );
endinterface

// File: rtl/taxi_axis_cobs_decode.sv
// taxi_axis_cobs_decode: AXI4-Stream COBS frame decoder.
// Define TAXI_COBS_DECODE_STATUS_EN to drive the frame status pulses.
module taxi_axis_cobs_decode (
  input  logic clk,
  input  logic rst,
  taxi_axis_cobs_decode_if.snk s_axis,
  taxi_axis_cobs_decode_if.src m_axis,
  output logic status_good_frame,
  output logic status_bad_frame
);
  localparam int S_DATA_W = s_axis.DATA_W;
  localparam int M_DATA_W = m_axis.DATA_W;
  localparam int M_USER_W = m_axis.USER_W;

  if (S_DATA_W != 8) begin : g_s_width
    $fatal(1, "s_axis.DATA_W must be 8");
  end
  if (M_DATA_W != 8) begin : g_m_width
    $fatal(1, "m_axis.DATA_W must be 8");
  end

  typedef enum logic [1:0] {IDLE, SEGMENT, NEXT} state_t;

  state_t     state;
  state_t     state_n;
  logic [7:0] count;
  logic [7:0] count_n;
  logic       suppress;
  logic       suppress_n;

  logic [7:0] hold;
  logic       hold_v;
  logic       flush;
  logic       flush_bad;

  logic       buf_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_user;
  logic       tmp_valid;
  logic [7:0] tmp_data;
  logic       tmp_last;
  logic       tmp_user;

  logic       fire;
  logic       nb;
  logic [7:0] nbd;
  logic       fend;
  logic       fbad;
  logic [7:0] d;

  logic       push;
  logic [7:0] p_data;
  logic       p_last;
  logic       p_user;
  logic       ready_early;

  logic unused;
  assign unused = ^{s_axis.tkeep, s_axis.tstrb};

  assign d    = s_axis.tdata;
  assign fire = s_axis.tvalid && s_axis.tready;

  assign s_axis.tready = buf_ready && !flush;

  assign m_axis.tvalid = m_valid;
  assign m_axis.tdata  = m_data;
  assign m_axis.tlast  = m_last;
  assign m_axis.tuser  = M_USER_W'(m_user);
  assign m_axis.tkeep  = '1;
  assign m_axis.tstrb  = '1;

  always_comb begin
    state_n    = state;
    count_n    = count;
    suppress_n = suppress;
    nb         = 1'b0;
    nbd        = d;
    fend       = 1'b0;
    fbad       = 1'b0;
    unique case (state)
      IDLE: begin
        if (d != 8'h00) begin
          count_n    = d - 8'd1;
          suppress_n = (d == 8'hff);
          state_n    = (d == 8'h01) ? NEXT : SEGMENT;
        end
      end
      SEGMENT: begin
        if (d == 8'h00) begin
          fend = 1'b1;
          fbad = 1'b1;
        end else begin
          nb      = 1'b1;
          count_n = count - 8'd1;
          if (count == 8'd1) state_n = NEXT;
        end
      end
      NEXT: begin
        if (d == 8'h00) begin
          fend = 1'b1;
        end else begin
          nb         = !suppress;
          nbd        = 8'h00;
          count_n    = d - 8'd1;
          suppress_n = (d == 8'hff);
          state_n    = (d == 8'h01) ? NEXT : SEGMENT;
        end
      end
      default: state_n = IDLE;
    endcase
    // idle fill carries no frame, even with tlast
    if (s_axis.tlast && !(state == IDLE && d == 8'h00)) begin
      fend = 1'b1;
      fbad = fbad || (state_n == SEGMENT) || s_axis.tuser[0];
    end
    if (fend) state_n = IDLE;
  end

  // A byte decoded on the ending beat while another is held needs
  // a second output beat; flush stalls the input for one push.
  always_comb begin
    push   = 1'b0;
    p_data = hold;
    p_last = 1'b0;
    p_user = 1'b0;
    if (flush) begin
      push   = buf_ready;
      p_last = 1'b1;
      p_user = flush_bad;
    end else if (fire) begin
      if (nb && hold_v) begin
        push = 1'b1;
      end else if (nb && fend) begin
        push   = 1'b1;
        p_data = nbd;
        p_last = 1'b1;
        p_user = fbad;
      end else if (fend && hold_v) begin
        push   = 1'b1;
        p_last = 1'b1;
        p_user = fbad;
      end
    end
  end

  assign ready_early = m_axis.tready ||
    (!tmp_valid && (!m_valid || !push));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 8'd0;
      suppress  <= 1'b0;
      hold_v    <= 1'b0;
      flush     <= 1'b0;
      flush_bad <= 1'b0;
      buf_ready <= 1'b0;
      m_valid   <= 1'b0;
      tmp_valid <= 1'b0;
    end else begin
      buf_ready <= ready_early;
      if (flush && buf_ready) begin
        flush  <= 1'b0;
        hold_v <= 1'b0;
      end
      if (fire) begin
        state    <= state_n;
        count    <= count_n;
        suppress <= suppress_n;
        if (nb) begin
          hold      <= nbd;
          hold_v    <= hold_v || !fend;
          flush     <= fend && hold_v;
          flush_bad <= fbad;
        end else if (fend) begin
          hold_v <= 1'b0;
        end
      end
      if (buf_ready) begin
        if (m_axis.tready || !m_valid) begin
          m_valid <= push;
          m_data  <= p_data;
          m_last  <= p_last;
          m_user  <= p_user;
        end else begin
          tmp_valid <= push;
          tmp_data  <= p_data;
          tmp_last  <= p_last;
          tmp_user  <= p_user;
        end
      end else if (m_axis.tready) begin
        m_valid   <= tmp_valid;
        m_data    <= tmp_data;
        m_last    <= tmp_last;
        m_user    <= tmp_user;
        tmp_valid <= 1'b0;
      end
    end
  end

`ifdef TAXI_COBS_DECODE_STATUS_EN
  logic good_p;
  logic bad_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      good_p <= 1'b0;
      bad_p  <= 1'b0;
    end else begin
      good_p <= fire && fend && !fbad && (hold_v || nb);
      bad_p  <= fire && fend && fbad;
    end
  end

  assign status_good_frame = good_p;
  assign status_bad_frame  = bad_p;
`else
  assign status_good_frame = 1'b0;
  assign status_bad_frame  = 1'b0;
`endif
endmodule

// File: tb/tb_taxi_axis_cobs_decode.sv
// tb_taxi_axis_cobs_decode: directed and round-trip checks
// for the COBS decoder.
module tb_taxi_axis_cobs_decode;
  typedef logic [7:0] bq_t[$];
  typedef logic [9:0] tq_t[$];

`ifdef TAXI_COBS_DECODE_STATUS_EN
  localparam bit ST = 1'b1;
`else
  localparam bit ST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic status_good_frame;
  logic status_bad_frame;
  logic throttle = 1'b0;

  int checks = 0;
  int errors = 0;
  int good_cnt = 0;
  int bad_cnt = 0;
  int g0 = 0;
  int b0 = 0;

  tq_t got;
  tq_t exp;

  taxi_axis_cobs_decode_if s_axis ();
  taxi_axis_cobs_decode_if m_axis ();

  taxi_axis_cobs_decode dut (
    .clk(clk),
    .rst(rst),
    .s_axis(s_axis),
    .m_axis(m_axis),
    .status_good_frame(status_good_frame),
    .status_bad_frame(status_bad_frame)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_axis.tvalid && m_axis.tready)
      got.push_back({m_axis.tuser[0], m_axis.tlast, m_axis.tdata});
    if (status_good_frame) good_cnt++;
    if (status_bad_frame) bad_cnt++;
  end

  initial begin
    m_axis.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis.tready = throttle ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic s(input logic [7:0] dd, input logic l = 1'b0,
                   input logic u = 1'b0);
    int n;
    n = 0;
    s_axis.tdata  = dd;
    s_axis.tlast  = l;
    s_axis.tuser  = u;
    s_axis.tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis.tready && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 1000) chk("send_timeout", n, 0);
    @(posedge clk);
    #1;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    s_axis.tuser  = 1'b0;
  endtask

  task automatic e(input logic [7:0] dd, input logic l = 1'b0,
                   input logic u = 1'b0);
    exp.push_back({u, l, dd});
  endtask

  task automatic start_test();
    got.delete();
    exp.delete();
    g0 = good_cnt;
    b0 = bad_cnt;
  endtask

  task automatic check_out(input string tag, input int ge, input int be);
    int t;
    t = 0;
    while (got.size() < exp.size() && t < 20000) begin
      @(negedge clk);
      t++;
    end
    repeat (6) @(negedge clk);
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
    chk({tag, "_good"}, good_cnt - g0, ST ? ge : 0);
    chk({tag, "_bad"}, bad_cnt - b0, ST ? be : 0);
    got.delete();
    exp.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", m_axis.tvalid, 1'b0);
    chk("rst_s_tready", s_axis.tready, 1'b0);
    chk("rst_status", {status_good_frame, status_bad_frame}, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tready_first", s_axis.tready, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic cobs_enc(input bq_t raw, output bq_t enc);
    bq_t blk;
    enc.delete();
    blk.delete();
    foreach (raw[i]) begin
      if (raw[i] == 8'h00) begin
        enc.push_back(8'(blk.size() + 1));
        foreach (blk[j]) enc.push_back(blk[j]);
        blk.delete();
      end else begin
        blk.push_back(raw[i]);
        if (blk.size() == 254) begin
          enc.push_back(8'hff);
          foreach (blk[j]) enc.push_back(blk[j]);
          blk.delete();
        end
      end
    end
    enc.push_back(8'(blk.size() + 1));
    foreach (blk[j]) enc.push_back(blk[j]);
    enc.push_back(8'h00);
  endtask

  initial begin
    bq_t raw;
    bq_t enc;
    int len;
    int nfr;

    s_axis.tvalid = 1'b0;
    s_axis.tdata  = 8'h00;
    s_axis.tlast  = 1'b0;
    s_axis.tuser  = 1'b0;
    s_axis.tkeep  = 1'b1;
    s_axis.tstrb  = 1'b1;

    do_reset();
    chk("tkeep_tstrb", {30'd0, m_axis.tkeep, m_axis.tstrb}, 32'd3);

    start_test();
    s(8'h03); s(8'h11); s(8'h22); s(8'h02); s(8'h33); s(8'h00);
    e(8'h11); e(8'h22); e(8'h00); e(8'h33, 1'b1);
    check_out("basic", 1, 0);

    start_test();
    s(8'h01); s(8'h01); s(8'h00);
    e(8'h00, 1'b1);
    check_out("single_zero", 1, 0);

    start_test();
    s(8'h01); s(8'h00);
    check_out("empty", 0, 0);

    start_test();
    s(8'hff);
    for (int i = 0; i < 254; i++) begin
      s(8'h5a);
      e(8'h5a);
    end
    s(8'h02); s(8'h7e); s(8'h00);
    e(8'h7e, 1'b1);
    check_out("code_ff", 1, 0);

    start_test();
    s(8'h04); s(8'h11); s(8'h22); s(8'h00);
    e(8'h11); e(8'h22, 1'b1, 1'b1);
    check_out("truncated", 0, 1);

    start_test();
    s(8'h02); s(8'h99); s(8'h00);
    e(8'h99, 1'b1);
    check_out("recover", 1, 0);

    start_test();
    s(8'h03); s(8'haa); s(8'hbb, 1'b1);
    e(8'haa); e(8'hbb, 1'b1);
    check_out("tlast_end", 1, 0);

    start_test();
    s(8'h03); s(8'haa); s(8'hbb, 1'b1, 1'b1);
    e(8'haa); e(8'hbb, 1'b1, 1'b1);
    check_out("tlast_tuser", 0, 1);

    start_test();
    s(8'h02, 1'b1); s(8'h01, 1'b1);
    check_out("code_tlast", 0, 1);

    start_test();
    s(8'h00); s(8'h00); s(8'h02); s(8'h55); s(8'h00);
    e(8'h55, 1'b1);
    check_out("idle_fill", 1, 0);

    start_test();
    s(8'h04); s(8'h11);
    do_reset();
    s(8'h02); s(8'h99); s(8'h00);
    e(8'h99, 1'b1);
    check_out("rst_mid", 1, 0);

    throttle = 1'b1;
    start_test();
    nfr = 0;
    for (int f = 0; f < 60; f++) begin
      len = (f % 10 == 9) ? 300 : $urandom_range(0, 24);
      raw.delete();
      for (int i = 0; i < len; i++)
        raw.push_back(($urandom_range(0, 4) == 0) ?
                      8'h00 : 8'($urandom_range(1, 255)));
      cobs_enc(raw, enc);
      for (int i = 0; i < len; i++)
        e(raw[i], i == len - 1);
      if (len > 0) nfr++;
      if (f % 2 == 1) begin
        void'(enc.pop_back());
        for (int i = 0; i < enc.size(); i++)
          s(enc[i], i == enc.size() - 1);
      end else begin
        foreach (enc[i]) s(enc[i]);
      end
    end
    check_out("roundtrip", nfr, 0);
    throttle = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
